// File: rtl/keychain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keychain_pkg
//  Description : Shared types for the key-chain arithmetic blocks: the
//                modular-exponentiation FSM state encoding and a helper that
//                gives the length of one reducer step in clock cycles.
//  Revision    : 1.0  initial release
// ============================================================================
package keychain_pkg;

   // Explicit 3-bit encoding for the exponentiation controller.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SQ   = 3'd2,
      MUL  = 3'd3,
      DONE = 3'd4
   } state_e;

   // One reduce step: start pulse, 2*W shift-subtract iterations, capture.
   function automatic int reduce_cycles(input int width);
      return 2 * width + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mod_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : mod_reduce
//  Description : Restoring shift-subtract reducer. Computes value_i mod
//                modulus_i for a 2*WIDTH dividend and WIDTH-bit modulus.
//                value_i is sampled on the edge where start_i is high; the
//                remainder is valid while done_o pulses, 2*WIDTH+1 cycles
//                after that edge. modulus_i must stay stable for the whole run
//                and must be non-zero.
//  Ports       : clk_in, rst_n_in (async, active low), start_i, value_i,
//                modulus_i, rem_o, done_o
//  Revision    : 1.0  initial release
// ============================================================================
module mod_reduce
   import keychain_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_i,
   input  logic [2*WIDTH-1:0]   value_i,
   input  logic [WIDTH-1:0]     modulus_i,
   output logic [WIDTH-1:0]     rem_o,
   output logic                 done_o
);

   localparam int              CNT_W    = $clog2(2 * WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

   logic [2*WIDTH-1:0] val_q;
   logic [WIDTH-1:0]   rem_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               active_q;
   logic               done_q;

   // Partial remainder shifted left with the next dividend bit. It needs
   // WIDTH+1 bits because rem_q can reach modulus-1 = 2^WIDTH-2.
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      trial = {rem_q, val_q[2*WIDTH-1]};
      diff  = trial - {1'b0, modulus_i};
      ge    = (trial >= {1'b0, modulus_i});
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         val_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            val_q    <= value_i;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
         end else if (active_q) begin
            // Both branches are below the modulus, so the top bit is zero.
            rem_q <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            val_q <= {val_q[2*WIDTH-2:0], 1'b0};
            if (cnt_q == CNT_LAST) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign rem_o  = rem_q;
   assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/mod_exp.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp
//  Description : Left-to-right square-and-multiply modular exponentiation,
//                result_out = base^exponent mod modulus. Every square or
//                multiply is followed by a full 2*WIDTH reduction in
//                mod_reduce, so no product is ever truncated.
//                Optional build macro MOD_EXP_SKIP_ZEROS_EN: start the bit
//                scan at the most significant set exponent bit, skipping the
//                leading squarings of 1. Results are identical either way.
//  Ports       : clk_in, rst_n_in (async, active low), ready_in, base_in,
//                exponent_in, modulus_in -> result_out, busy_out,
//                valid_out (1-cycle pulse), err_out (modulus was 0)
//  Revision    : 1.0  initial release
// ============================================================================
module mod_exp
   import keychain_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             ready_in,
   input  logic [WIDTH-1:0] base_in,
   input  logic [WIDTH-1:0] exponent_in,
   input  logic [WIDTH-1:0] modulus_in,
   output logic [WIDTH-1:0] result_out,
   output logic             busy_out,
   output logic             valid_out,
   output logic             err_out
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q;
   logic [WIDTH-1:0]   base_q, exp_q, mod_q;
   logic [WIDTH-1:0]   b_q, acc_q;
   logic [IDX_W-1:0]   idx_q;
   logic               run_q;     // a reduce step has been issued in this op
   logic               start_q;
   logic [WIDTH-1:0]   result_q;
   logic               busy_q, valid_q, err_q;

   logic [2*WIDTH-1:0] red_value;
   logic [WIDTH-1:0]   red_rem;
   logic               red_done;

   // Dividend for the step in flight; sampled by the reducer one cycle after
   // the state is entered, when acc_q already holds the previous result.
   always_comb begin
      red_value = '0;
      case (state_q)
         LOAD:    red_value = {{WIDTH{1'b0}}, base_q};
         SQ:      red_value = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, acc_q};
         MUL:     red_value = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, b_q};
         default: red_value = '0;
      endcase
   end

`ifdef MOD_EXP_SKIP_ZEROS_EN
   logic [IDX_W-1:0] msb_idx;
   logic             exp_nonzero;

   always_comb begin
      msb_idx     = '0;
      exp_nonzero = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (exp_q[k]) begin
            msb_idx     = IDX_W'(k);
            exp_nonzero = 1'b1;
         end
      end
   end
`endif

   mod_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .start_i   (start_q),
      .value_i   (red_value),
      .modulus_i (mod_q),
      .rem_o     (red_rem),
      .done_o    (red_done)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         base_q   <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         run_q    <= 1'b0;
         start_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ready_in) begin
                  base_q  <= base_in;
                  exp_q   <= exponent_in;
                  mod_q   <= modulus_in;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  run_q   <= 1'b0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               if (!run_q) begin
                  // Zero modulus is caught before any reduction is issued,
                  // so the reducer never divides by zero.
                  if (mod_q == '0) begin
                     acc_q   <= '0;
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     start_q <= 1'b1;
                     run_q   <= 1'b1;
                  end
               end else if (red_done) begin
                  b_q   <= red_rem;
                  acc_q <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
`ifdef MOD_EXP_SKIP_ZEROS_EN
                  if (!exp_nonzero) begin
                     state_q <= DONE;
                     run_q   <= 1'b0;
                  end else begin
                     idx_q   <= msb_idx;
                     state_q <= SQ;
                     start_q <= 1'b1;
                  end
`else
                  idx_q   <= IDX_W'(WIDTH - 1);
                  state_q <= SQ;
                  start_q <= 1'b1;
`endif
               end
            end
            SQ: begin
               if (red_done) begin
                  acc_q <= red_rem;
                  if (exp_q[idx_q]) begin
                     state_q <= MUL;
                     start_q <= 1'b1;
                  end else if (idx_q == '0) begin
                     state_q <= DONE;
                     run_q   <= 1'b0;
                  end else begin
                     idx_q   <= idx_q - IDX_W'(1);
                     start_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               // The bit-advance decision shares the capture cycle.
               if (red_done) begin
                  acc_q <= red_rem;
                  if (idx_q == '0) begin
                     state_q <= DONE;
                     run_q   <= 1'b0;
                  end else begin
                     idx_q   <= idx_q - IDX_W'(1);
                     state_q <= SQ;
                     start_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               result_q <= acc_q;
               busy_q   <= 1'b0;
               valid_q  <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result_out = result_q;
   assign busy_out   = busy_q;
   assign valid_out  = valid_q;
   assign err_out    = err_q;

endmodule
`default_nettype wire

// File: doc/mod_exp.md
Name: mod_exp

Overview:
- Modular exponentiation engine: computes base^exponent mod modulus by left-to-right square-and-multiply.
- Sits directly downstream of the squaring/reduction stage. It issues a square-then-reduce step per exponent bit, plus a multiply-then-reduce step per set bit.
- Uses the same ready/busy/valid handshake as the other arithmetic blocks, so the key-generation and encrypt/decrypt controllers can chain it.

Parameters:
- WIDTH, 16, bit width of base, exponent, modulus and result; products are 2*WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- ready_in  input  1  start request; sampled only while idle
- base_in  input  WIDTH  base; latched on accept
- exponent_in  input  WIDTH  exponent; latched on accept
- modulus_in  input  WIDTH  modulus; latched on accept
- result_out  output  WIDTH  base^exponent mod modulus; held until next completion
- busy_out  output  1  high from the accept edge until the completion edge
- valid_out  output  1  one-cycle pulse on completion
- err_out  output  1  high with valid_out when modulus was 0; cleared on the next accept

Behaviour:
- Interface: one clock (clk_in); reset rst_n_in is asynchronous and active-low.
- Reset:
  - result_out=0, busy_out=0, valid_out=0, err_out=0.
  - FSM returns to IDLE and the internal reducer is cleared.
  - Reset asserted mid-operation aborts without a valid pulse.
- Accept: at a clk edge with state IDLE and ready_in=1:
  - latch all three operands; busy_out<=1.
  - ready_in while busy is ignored, and inputs may change freely.
- Reducer step R: start pulse, then 2*WIDTH restoring shift-subtract iterations, then a capture cycle. R = 2*WIDTH+2 cycles.
- FSM states and transitions:
  - IDLE -> LOAD on accept. If modulus=0, go to DONE instead with acc=0 and err=1.
  - LOAD: reduce zero-extended base mod m into b. Set acc = (m==1) ? 0 : 1. Set bit index i=WIDTH-1.
  - SQ: reduce acc*acc into acc. If exponent[i]=1, go to MUL; else go to NEXT.
  - MUL: reduce acc*b into acc, then go to NEXT.
  - NEXT: if i==0, go to DONE; else decrement i and go to SQ. NEXT costs zero extra cycles; the decision is folded into the capture cycle.
  - DONE: result_out<=acc, busy_out<=0, valid_out<=1 for exactly one cycle, then IDLE.
- A new accept is possible on the cycle after valid_out.
- Latency: from the accept edge to the valid_out-high edge, L = (1 + WIDTH + popcount(exponent))*(2*WIDTH+2) + 2 cycles, exactly.
  - modulus=0 path: L = 2.
- Arithmetic:
  - All products are 2*WIDTH, with no truncation before reduction.
  - Reducer intermediate is WIDTH+1 bits, so moduli up to 2^WIDTH-1 never overflow.
  - Result is always < modulus.
- Boundary conditions:
  - exponent=0 -> result 1 (or 0 if modulus=1).
  - base >= modulus is legal.
  - base=0 with exponent>0 -> 0.

Optional Feature:
- Macro: MOD_EXP_SKIP_ZEROS_EN.
- When defined:
  - LOAD additionally locates the most significant set exponent bit and starts i there.
  - Leading-zero squarings are skipped, since squaring 1 is a no-op.
  - Latency becomes (1 + nbits + popcount)*(2*WIDTH+2) + 2, where nbits = index of MSB set + 1, or 0 for exponent=0.
- When undefined: fixed WIDTH iterations and the latency formula above. Results are identical in both builds.

Decomposition:
- Shared package keychain_pkg holds:
  - the FSM state enum typedef (IDLE, LOAD, SQ, MUL, DONE);
  - localparam REDUCE_CYCLES(WIDTH) helper.
- One sub-module, mod_reduce, handles the start/done pulse shift-subtract reduction:
  - inputs: 2*WIDTH value and WIDTH modulus;
  - output: WIDTH remainder;
  - done pulse after exactly 2*WIDTH+1 cycles following start.

Test Plan:
- base=4, exp=13, mod=497, WIDTH=16 -> result_out=445, valid_out one cycle at L=682 (skip build: nbits=4 -> L=274), err_out=0.
- exp=0, base=1234, mod=1000 -> result 1; then mod=1 -> result 0; both with busy_out low after valid.
- mod=0, any base/exp -> valid_out at cycle 2, result_out=0, err_out=1; next accept with mod=7 clears err_out.
- Max values: base=65535, exp=65535, mod=65521 -> result matches the reference model; verifies there is no overflow in the 2*WIDTH product or reducer.
- Handshake: pulse ready_in and change operands while busy -> ignored, result from the first operands; back-to-back accept on the cycle after valid works.
- Assert rst_n_in mid-SQ -> all outputs 0 asynchronously, no valid pulse; after release, a fresh run of 3^5 mod 7 -> 5.
